// File: rtl/mem_access_unit.sv
// Load/store unit for the EX/MEM stage: issues word-aligned memory requests, waits
// for completion with a timeout, and produces one write-back pulse per instruction.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [4:0]  rd,
  input  logic        RegWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWrite,
  output logic [1:0]  wb_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        mem_op, illegal, misaligned, accept_mem, time_out;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lo;
  logic [31:0] r_alu;
  logic [4:0]  r_rd;
  logic        r_regwrite, r_load;
  logic [31:0] rd_shift, load_data;

  assign mem_op  = MemRead | MemWrite;
  assign illegal = (MemRead & MemWrite)
                 | (MemWrite & (funct3 > 3'b010))
                 | (MemRead & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)));

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = ALUResult[0];
      2'b10:   misaligned = (ALUResult[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign accept_mem = in_valid & mem_op & ~illegal & ~misaligned;
  assign time_out   = ~dmem_ack & (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Stall drops on the final WAIT cycle (ack or timeout) so upstream advances
  // in step with the write-back pulse that follows.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: if (accept_mem) begin
        state_next = WAIT;
        stall      = 1'b1;
      end
      WAIT: if (dmem_ack || time_out) state_next = IDLE;
            else                      stall      = 1'b1;
      default: state_next = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  assign rd_shift = dmem_rdata >> {r_lo, 3'b000};

  always_comb begin
    load_data = dmem_rdata;
    case (r_funct3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_data = {24'd0, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_data = {16'd0, rd_shift[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_wstrb  <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_RegWrite <= 1'b0;
      wb_err      <= 2'b00;
      r_funct3    <= '0;
      r_lo        <= '0;
      r_alu       <= '0;
      r_rd        <= '0;
      r_regwrite  <= 1'b0;
      r_load      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (in_valid && !mem_op) begin
            wb_valid    <= 1'b1;
            wb_data     <= ALUResult;
            wb_rd       <= rd;
            wb_RegWrite <= RegWrite;
            wb_err      <= 2'b00;
          end else if (in_valid && (illegal || misaligned)) begin
            wb_valid    <= 1'b1;
            wb_data     <= ALUResult;
            wb_rd       <= rd;
            wb_RegWrite <= 1'b0;
            wb_err      <= illegal ? 2'b11 : 2'b01;
          end else if (accept_mem) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite;
            dmem_addr  <= {ALUResult[31:2], 2'b00};
            r_funct3   <= funct3;
            r_lo       <= ALUResult[1:0];
            r_alu      <= ALUResult;
            r_rd       <= rd;
            r_regwrite <= RegWrite;
            r_load     <= MemRead;
            case (funct3[1:0])
              2'b00: begin
                dmem_wstrb <= MemWrite ? (4'b0001 << ALUResult[1:0]) : 4'b0000;
                dmem_wdata <= {4{WriteData[7:0]}};
              end
              2'b01: begin
                dmem_wstrb <= MemWrite ? (4'b0011 << ALUResult[1:0]) : 4'b0000;
                dmem_wdata <= {2{WriteData[15:0]}};
              end
              default: begin
                dmem_wstrb <= MemWrite ? 4'b1111 : 4'b0000;
                dmem_wdata <= WriteData;
              end
            endcase
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            wb_valid    <= 1'b1;
            wb_data     <= r_load ? load_data : r_alu;
            wb_rd       <= r_rd;
            wb_RegWrite <= r_load & r_regwrite;
            wb_err      <= 2'b00;
          end else if (time_out) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            wb_valid    <= 1'b1;
            wb_data     <= r_alu;
            wb_rd       <= r_rd;
            wb_RegWrite <= 1'b0;
            wb_err      <= 2'b10;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected write-backs are queued at issue and
// checked by an independent monitor whenever wb_valid is seen.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, MemRead, MemWrite, RegWrite, dmem_ack;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData, dmem_rdata;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, stall, wb_valid, wb_RegWrite;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  err;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData), .rd(rd), .RegWrite(RegWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite), .wb_err(wb_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_err", 32'(wb_err), 32'(e.err));
        check("wb_RegWrite", 32'(wb_RegWrite), 32'(e.rw));
        if (e.chk_data) check("wb_data", wb_data, e.data);
        if (e.rw) check("wb_rd", 32'(wb_rd), 32'(e.rd));
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic [4:0] r, input logic rw,
                      input logic [1:0] err, input logic cd);
    exp_t e;
    e.data = d; e.rd = r; e.rw = rw; e.err = err; e.chk_data = cd;
    sb.push_back(e);
  endtask

  task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] r, input logic rw);
    in_valid = 1'b1; MemRead = mr; MemWrite = mw; funct3 = f3;
    ALUResult = addr; WriteData = wd; rd = r; RegWrite = rw;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // nwait: WAIT cycles without ack before the ack cycle; >=15 means never ack.
  task automatic run_mem(input string nm, input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] r,
                         input int nwait, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata, input logic [31:0] e_data);
    int stalls = 0;
    int reqs = 0;
    bit held = 1'b1;
    @(posedge clk); #1;
    drive(mr, mw, f3, addr, wd, r, 1'b1);
    if (nwait >= 15) push(addr, r, 1'b0, 2'b10, 1'b0);
    else             push(e_data, r, mr, 2'b00, 1'b1);
    @(negedge clk);
    if (stall) stalls++;
    @(posedge clk); #1;
    idle_in();
    for (int i = 0; i < 15; i++) begin
      if (i == nwait) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
      @(negedge clk);
      if (dmem_req) reqs++;
      if (stall) stalls++;
      if (dmem_addr !== e_addr || dmem_wstrb !== e_strb || dmem_we !== mw ||
          (mw && dmem_wdata !== e_wdata) || dmem_req !== 1'b1) held = 1'b0;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (i == nwait) break;
    end
    check({nm, "_req_held"}, 32'(held), 32'd1);
    @(negedge clk);
    check({nm, "_req_drop"}, 32'(dmem_req), 32'd0);
    check({nm, "_stall_rel"}, 32'(stall), 32'd0);
    if (nwait >= 15) check({nm, "_req_cycles"}, 32'(reqs), 32'd15);
    else             check({nm, "_stall_cycles"}, 32'(stalls), 32'(nwait + 1));
  endtask

  task automatic run_err(input string nm, input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [1:0] e_err);
    @(posedge clk); #1;
    drive(mr, mw, f3, addr, 32'h0, 5'd7, 1'b1);
    push(addr, 5'd7, 1'b0, e_err, 1'b0);
    @(negedge clk);
    check({nm, "_stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);
    check({nm, "_no_req"}, 32'(dmem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 1'b1);
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_wb_valid", 32'(wb_valid), 32'd0);
    check("reset_req", 32'(dmem_req), 32'd0);
    check("reset_we", 32'(dmem_we), 32'd0);
    check("reset_wstrb", 32'(dmem_wstrb), 32'd0);
    check("reset_addr", dmem_addr, 32'd0);
    check("reset_wdata", dmem_wdata, 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    check("reset_wb_rd", 32'(wb_rd), 32'd0);
    check("reset_wb_err", 32'(wb_err), 32'd0);
    check("reset_wb_rw", 32'(wb_RegWrite), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; idle_in();
    @(negedge clk);
    check("idle_no_wb", 32'(wb_valid), 32'd0);

    // Pass-through, then pulse width and hold of wb fields
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0, 5'd5, 1'b1);
    push(32'h12345678, 5'd5, 1'b1, 2'b00, 1'b1);
    @(negedge clk);
    check("pass_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);
    @(negedge clk);
    check("pass_pulse", 32'(wb_valid), 32'd0);
    check("pass_hold", wb_data, 32'h12345678);

    run_mem("lb",  1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 5'd3, 3, 32'h80FFFFFF,
            32'h1000, 4'b0000, 32'h0, 32'hFFFFFF80);
    run_mem("lbu", 1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 5'd4, 3, 32'h80FFFFFF,
            32'h1000, 4'b0000, 32'h0, 32'h00000080);
    run_mem("sh",  1'b0, 1'b1, 3'b001, 32'h2002, 32'hAAAABEEF, 5'd6, 0, 32'h0,
            32'h2000, 4'b1100, 32'hBEEFBEEF, 32'h2002);
    run_mem("sb",  1'b0, 1'b1, 3'b000, 32'h5001, 32'h123456A5, 5'd8, 1, 32'h0,
            32'h5000, 4'b0010, 32'hA5A5A5A5, 32'h5001);
    run_mem("sw",  1'b0, 1'b1, 3'b010, 32'h6000, 32'hDEADBEEF, 5'd9, 2, 32'h0,
            32'h6000, 4'b1111, 32'hDEADBEEF, 32'h6000);
    run_mem("lh",  1'b1, 1'b0, 3'b001, 32'h7002, 32'h0, 5'd10, 0, 32'h80011234,
            32'h7000, 4'b0000, 32'h0, 32'hFFFF8001);
    run_mem("lhu", 1'b1, 1'b0, 3'b101, 32'h7002, 32'h0, 5'd11, 1, 32'h80011234,
            32'h7000, 4'b0000, 32'h0, 32'h00008001);
    run_mem("lw",  1'b1, 1'b0, 3'b010, 32'h8000, 32'h0, 5'd12, 0, 32'hCAFEF00D,
            32'h8000, 4'b0000, 32'h0, 32'hCAFEF00D);
    run_mem("lw_ack_at_to", 1'b1, 1'b0, 3'b010, 32'h8004, 32'h0, 5'd13, 14, 32'h0BADF00D,
            32'h8004, 4'b0000, 32'h0, 32'h0BADF00D);
    run_mem("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h9000, 32'h0, 5'd14, 99, 32'h0,
            32'h9000, 4'b0000, 32'h0, 32'h0);

    run_err("lw_misal", 1'b1, 1'b0, 3'b010, 32'h3001, 2'b01);
    run_err("sh_misal", 1'b0, 1'b1, 3'b001, 32'h3003, 2'b01);
    run_err("rw_both",  1'b1, 1'b1, 3'b010, 32'h3001, 2'b11);
    run_err("st_f3",    1'b0, 1'b1, 3'b100, 32'h3000, 2'b11);
    run_err("ld_f3",    1'b1, 1'b0, 3'b011, 32'h3000, 2'b11);

    // Reset during the second WAIT cycle, late ack afterwards
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd15, 1'b1);
    @(posedge clk); #1;
    idle_in();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
    @(negedge clk);
    check("rst_wait_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("rst_late_ack", 32'(wb_valid), 32'd0);

    run_mem("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd16, 1, 32'h01234567,
            32'h4000, 4'b0000, 32'h0, 32'h01234567);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
